// File: rtl/fp_unpack.sv
// Operand unpacker: IEEE-754 single -> sign, widened biased exponent, 24-bit significand, class flags.
// Two-stage valid/ready pipeline; subnormals are normalized so bit 23 is set for nonzero finite values.
module fp_unpack (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [9:0]  out_exponent,
  output logic [23:0] out_significand,
  output logic        out_zero,
  output logic        out_inf,
  output logic        out_nan,
  output logic        out_snan,
  output logic        out_denorm
);

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_DENORM,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  fp_class_t   in_cls;
  logic [4:0]  in_lz;

  logic        s1_valid;
  fp_class_t   s1_cls;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_frac;
  logic [4:0]  s1_lz;

  logic [9:0]  s2_exp;
  logic [23:0] s2_sig;
  logic        advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;

  always_comb begin
    in_cls = CLS_NORMAL;
    in_lz  = '0;
    if (fp_in[30:23] == 8'h00) begin
      if (fp_in[22:0] == '0) begin
        in_cls = CLS_ZERO;
      end else begin
        in_cls = CLS_DENORM;
        // Last set bit scanning upward is the MSB of the fraction.
        for (int unsigned i = 0; i < 23; i++) begin
          if (fp_in[i]) in_lz = 5'(23 - i);
        end
      end
    end else if (fp_in[30:23] == 8'hFF) begin
      in_cls = (fp_in[22:0] == '0) ? CLS_INF : CLS_NAN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_NORMAL;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_lz    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cls  <= in_cls;
        s1_sign <= fp_in[31];
        s1_exp  <= fp_in[30:23];
        s1_frac <= fp_in[22:0];
        s1_lz   <= in_lz;
      end
    end
  end

  always_comb begin
    s2_exp = '0;
    s2_sig = '0;
    case (s1_cls)
      CLS_NORMAL: begin
        s2_exp = {2'b00, s1_exp};
        s2_sig = {1'b1, s1_frac};
      end
      CLS_DENORM: begin
        s2_exp = 10'd1 - {5'd0, s1_lz};
        s2_sig = {1'b0, s1_frac} << s1_lz;
      end
      CLS_INF: begin
        s2_exp = 10'd255;
        s2_sig = 24'h800000;
      end
      CLS_NAN: begin
        s2_exp = 10'd255;
        s2_sig = {1'b1, s1_frac};
      end
      default: begin
        s2_exp = '0;
        s2_sig = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_sign        <= 1'b0;
      out_exponent    <= '0;
      out_significand <= '0;
      out_zero        <= 1'b0;
      out_inf         <= 1'b0;
      out_nan         <= 1'b0;
      out_snan        <= 1'b0;
      out_denorm      <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign        <= s1_sign;
        out_exponent    <= s2_exp;
        out_significand <= s2_sig;
        out_zero        <= (s1_cls == CLS_ZERO);
        out_inf         <= (s1_cls == CLS_INF);
        out_nan         <= (s1_cls == CLS_NAN);
        out_snan        <= (s1_cls == CLS_NAN) && !s1_frac[22];
        out_denorm      <= (s1_cls == CLS_DENORM);
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// Bench for fp_unpack: directed and random words checked against an arithmetic reference model.
module tb_fp_unpack;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exponent;
  logic [23:0] out_significand;
  logic        out_zero, out_inf, out_nan, out_snan, out_denorm;

  fp_unpack dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent), .out_significand(out_significand),
    .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
    .out_snan(out_snan), .out_denorm(out_denorm)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [39:0] q[$];
  logic [9:0]  exp_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk(input logic s, input logic [9:0] e, input logic [23:0] sig,
                                     input logic z, input logic i, input logic n,
                                     input logic sn, input logic d);
    return {s, e, sig, z, i, n, sn, d};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {out_sign, out_exponent, out_significand,
            out_zero, out_inf, out_nan, out_snan, out_denorm};
  endfunction

  // Reference: value-level decode; subnormals normalized by doubling until the hidden bit appears.
  function automatic logic [39:0] model(input logic [31:0] w);
    int e = int'(w[30:23]);
    int f = int'(w[22:0]);
    int ex = 0;
    int sig = 0;
    logic z = 0, i = 0, n = 0, sn = 0, d = 0;
    if (e == 0 && f == 0) begin
      z = 1;
    end else if (e == 0) begin
      d = 1; sig = f; ex = 1;
      while (sig < 'h800000) begin
        sig = sig * 2;
        ex = ex - 1;
      end
    end else if (e == 255 && f == 0) begin
      i = 1; ex = 255; sig = 'h800000;
    end else if (e == 255) begin
      n = 1; ex = 255; sig = f + 'h800000; sn = (f < 'h400000);
    end else begin
      ex = e; sig = f + 'h800000;
    end
    return mk(w[31], 10'(ex), 24'(sig), z, i, n, sn, d);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [22:0] f;
    w = $urandom;
    f = 23'($urandom) >> $urandom_range(0, 22);
    case ($urandom_range(0, 4))
      0: w[30:23] = 8'($urandom_range(1, 254));
      1: begin w[30:23] = 8'h00; w[22:0] = (f == '0) ? 23'd1 : f; end
      2: begin w[30:23] = 8'h00; w[22:0] = '0; end
      3: begin w[30:23] = 8'hFF; w[22:0] = '0; end
      default: begin w[30:23] = 8'hFF; w[22:0] = (f == '0) ? 23'h400000 : f; end
    endcase
    return w;
  endfunction

  // Starts at a falling edge with inputs driven; returns at the next falling edge.
  task automatic cycle(output bit acc);
    logic [39:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      delivered++;
      exp_log.push_back(out_exponent);
      if (q.size() == 0) begin
        check("unexpected_output", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        check("result_vs_model", obs_vec(), e);
      end
    end
    if (acc) q.push_back(model(fp_in));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send_one(input string tag, input logic [31:0] w, input logic [39:0] e);
    bit acc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fp_in     = w;
    cycle(acc);
    check({tag, "_accept"}, acc, 1);
    in_valid = 1'b0;
    fp_in    = '0;
    check({tag, "_valid_early"}, out_valid, 0);
    cycle(acc);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, obs_vec(), e);
    cycle(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx;
    bit stalled;
    logic [39:0] snap;
    logic [31:0] bp_words[4];
    logic [9:0]  bp_exps[4];

    in_valid  = 1'b0;
    fp_in     = '0;
    out_ready = 1'b1;

    @(negedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", obs_vec(), 0);
    reset = 1'b0;
    @(negedge clock);

    send_one("one",       32'h3F800000, mk(0, 10'd127, 24'h800000, 0, 0, 0, 0, 0));
    send_one("denorm_lsb", 32'h00000001, mk(0, 10'h3EA, 24'h800000, 0, 0, 0, 0, 1));
    send_one("denorm_msb", 32'h00400000, mk(0, 10'd0,   24'h800000, 0, 0, 0, 0, 1));
    send_one("neg_zero",  32'h80000000, mk(1, 10'd0,   24'h000000, 1, 0, 0, 0, 0));
    send_one("neg_inf",   32'hFF800000, mk(1, 10'd255, 24'h800000, 0, 1, 0, 0, 0));
    send_one("qnan",      32'h7FC00000, mk(0, 10'd255, 24'hC00000, 0, 0, 1, 0, 0));
    send_one("snan",      32'h7F800001, mk(0, 10'd255, 24'h800001, 0, 0, 1, 1, 0));

    // Backpressure
    bp_words = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    bp_exps  = '{10'd128, 10'd128, 10'd129, 10'd129};
    exp_log.delete();
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      fp_in    = (idx < 4) ? bp_words[idx] : '0;
      stalled  = out_valid && !out_ready;
      snap     = obs_vec();
      cycle(acc);
      if (acc) idx++;
      if (c == 1) begin
        check("bp_accepts", idx, 2);
        check("bp_full_in_ready", in_ready, 0);
      end
      if (stalled) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", obs_vec(), snap);
      end
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      in_valid = (idx < 4);
      fp_in    = (idx < 4) ? bp_words[idx] : '0;
      cycle(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_drained", q.size(), 0);
    check("bp_count", exp_log.size(), 4);
    for (int i = 0; i < 4 && i < exp_log.size(); i++) check("bp_exp_order", exp_log[i], bp_exps[i]);

    // Full-rate random stream
    delivered = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1;
      fp_in    = rand_word();
      cycle(acc);
      check("rs_accept", acc, 1);
      if (c >= 1) check("rs_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    cycle(acc);
    cycle(acc);
    check("rs_delivered", delivered, 16);
    check("rs_empty", q.size(), 0);

    // Reset with two words in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      fp_in    = rand_word();
      cycle(acc);
      check("rst_fill_accept", acc, 1);
    end
    in_valid = 1'b0;
    check("rst_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", obs_vec(), 0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    delivered = 0;
    send_one("post_reset", 32'h3F800000, mk(0, 10'd127, 24'h800000, 0, 0, 0, 0, 0));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle(acc);
    check("post_reset_count", delivered, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
